addsub_seq_acc: RTL

//  Parametrised multi-cycle two's-complement adder/subtractor with an internal accumulator.

---
 rtl/addsub_seq_acc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/addsub_seq_acc.sv
// addsub_seq_acc: chunked ripple add/sub with accumulator, flags and optional saturation.
module addsub_seq_acc #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_last,
  output logic             c_out,
  output logic             ovf,
  output logic             sat_hit,
  output logic [WIDTH-1:0] acc
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic carry_q, carry_d, c_last_q, c_last_d, c_out_q, c_out_d, sat_q, sat_d;
  logic clr_q, clr_d, accop_q, accop_d, rdy_q;
  logic [CHUNK:0] sum;
  logic last;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    acc_d    = acc_q;
    k_d      = k_q;
    carry_d  = carry_q;
    c_last_d = c_last_q;
    c_out_d  = c_out_q;
    sat_d    = sat_q;
    clr_d    = clr_q;
    accop_d  = accop_q;
    last     = k_q == KW'(N - 1);
    sum      = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
    unique case (state_q)
      IDLE: if (in_valid && rdy_q) begin
        state_d = CALC;
        k_d     = '0;
        clr_d   = op[2];
        accop_d = op[1];
        a_d     = op[1] ? acc_q : x;
        b_d     = (op[1] ? x : y) ^ {WIDTH{op[0]}};
        carry_d = op[0];
      end
      CALC: if (clr_q) begin
        state_d  = DONE;
        s_d      = '0;
        acc_d    = '0;
        c_last_d = 1'b0;
        c_out_d  = 1'b0;
        sat_d    = 1'b0;
      end else begin
        s_d[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        k_d     = k_q + KW'(1);
        if (last) begin
          state_d  = DONE;
          c_out_d  = sum[CHUNK];
          // carry into the MSB recovered from its sum bit and operand bits
          c_last_d = sum[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
          sat_d    = (SAT != 0) && (c_last_d ^ c_out_d);
          if (sat_d) s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          if (accop_q) acc_d = s_d;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      c_last_q <= 1'b0;
      c_out_q  <= 1'b0;
      sat_q    <= 1'b0;
      clr_q    <= 1'b0;
      accop_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= state_d == IDLE;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      c_last_q <= c_last_d;
      c_out_q  <= c_out_d;
      sat_q    <= sat_d;
      clr_q    <= clr_d;
      accop_q  <= accop_d;
    end
  end
  assign in_ready  = rdy_q;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign c_last    = c_last_q;
  assign c_out     = c_out_q;
  assign ovf       = c_last_q ^ c_out_q;
  assign sat_hit   = sat_q;
  assign acc       = acc_q;
endmodule
